// File: rtl/psum_acc_sched_if.sv
// Partial-sum input and accumulated-result output handshakes of psum_acc_sched.
// master = producer/consumer side (MAC + downstream), slave = the scheduler.
interface psum_acc_sched_if #(
  parameter int unsigned DW = 25
);
  logic          psum_valid;
  logic          psum_ready;
  logic [DW-1:0] psum_data;
  logic          acc_valid;
  logic          acc_ready;
  logic [DW-1:0] acc_data;

  modport master (
    output psum_valid, psum_data, acc_ready,
    input  psum_ready, acc_valid, acc_data
  );

  modport slave (
    input  psum_valid, psum_data, acc_ready,
    output psum_ready, acc_valid, acc_data
  );
endinterface

// File: rtl/psum_acc_sched.sv
// Accumulates num_pass signed partial sums into one result and hands it downstream.
// Define PSUM_ACC_SAT_EN to clamp on signed overflow; default build wraps modulo 2^DW.
module psum_acc_sched #(
  parameter int unsigned DW    = 25,
  parameter int unsigned CNT_W = 4
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             sys_en,
  input  logic             start,
  input  logic [CNT_W-1:0] num_pass,
  psum_acc_sched_if.slave  bus,
  output logic             busy,
  output logic             ovf
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] npass_q, npass_d;
  logic             ovf_q, ovf_d;

  logic [DW-1:0]    sum;
  logic [DW-1:0]    add_val;
  logic [CNT_W-1:0] cnt_inc;
  logic             ovf_add;
  logic             psum_hs;

  // Same-sign operands producing a different-sign sum is a signed overflow.
  assign sum     = acc_q + bus.psum_data;
  assign ovf_add = (acc_q[DW-1] == bus.psum_data[DW-1]) && (sum[DW-1] != acc_q[DW-1]);
  assign cnt_inc = cnt_q + CNT_W'(1);

`ifdef PSUM_ACC_SAT_EN
  localparam logic [DW-1:0] MAX_POS = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};
  assign add_val = ovf_add ? (acc_q[DW-1] ? MIN_NEG : MAX_POS) : sum;
`else
  assign add_val = sum;
`endif

  // psum_ready must fall in the same cycle sys_en drops, so it is decoded, not flopped.
  assign bus.psum_ready = (state_q == ST_ACC) && sys_en;
  assign psum_hs        = bus.psum_valid && bus.psum_ready;

  assign bus.acc_valid = (state_q == ST_DONE);
  assign bus.acc_data  = acc_q;
  assign busy          = (state_q != ST_IDLE);
  assign ovf           = ovf_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      npass_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      npass_q <= npass_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    npass_d = npass_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sys_en && start && (num_pass != '0)) begin
          npass_d = num_pass;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        if (psum_hs) begin
          acc_d = add_val;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | ovf_add;
          if (cnt_inc == npass_q) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (sys_en && bus.acc_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_psum_acc_sched.sv
// Randomized self-checking bench for psum_acc_sched against an integer-arithmetic job model.
// Honours PSUM_ACC_SAT_EN the same way the design does.
module tb_psum_acc_sched;
  localparam int unsigned DW    = 25;
  localparam int unsigned CNT_W = 4;
  localparam longint MAXV = 64'sd16777215;
  localparam longint MINV = -64'sd16777216;

  logic             sys_clk;
  logic             rst_n;
  logic             sys_en;
  logic             start;
  logic [CNT_W-1:0] num_pass;
  logic             busy;
  logic             ovf;

  psum_acc_sched_if #(.DW(DW)) bus ();

  psum_acc_sched #(.DW(DW), .CNT_W(CNT_W)) u_dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .sys_en   (sys_en),
    .start    (start),
    .num_pass (num_pass),
    .bus      (bus),
    .busy     (busy),
    .ovf      (ovf)
  );

  int n_chk;
  int n_err;
  logic [DW-1:0] exp_acc;
  bit            exp_ovf;
  logic [DW-1:0] data_q[$];
  logic [1:0]    pat_q[$];

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Exact integer sum, then range test; returns {overflow, new accumulator}.
  function automatic logic [DW:0] ref_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint s;
    bit     o;
    s = longint'($signed(a)) + longint'($signed(b));
    o = (s > MAXV) || (s < MINV);
`ifdef PSUM_ACC_SAT_EN
    if (s > MAXV) s = MAXV;
    else if (s < MINV) s = MINV;
`endif
    return {o, DW'(s)};
  endfunction

  function automatic logic [DW-1:0] rand_psum();
    logic [DW-1:0] d;
    case ($urandom % 3)
      0:       d = DW'(int'($urandom_range(0, 400)) - 200);
      1:       d = DW'($urandom);
      default: d = ($urandom % 2) ? DW'(MAXV - longint'($urandom_range(0, 3)))
                                  : DW'(MINV + longint'($urandom_range(0, 3)));
    endcase
    return d;
  endfunction

  // mode 0: back-to-back, 1: random stalls/freeze/backpressure, 2: pat_q stalls + 5-cycle hold
  task automatic run_job(input int p, input int mode);
    int            cyc;
    int            k;
    int            budget;
    int            hold;
    bit            en;
    bit            vl;
    logic [1:0]    pt;
    logic [DW-1:0] d;
    logic [DW:0]   r;

    start = 1'b1; num_pass = CNT_W'(p); sys_en = 1'b1;
    bus.psum_valid = 1'b0; bus.acc_ready = 1'b0;
    tick();
    start = 1'b0;
    cyc = 1;
    chk("busy_on", 32'(busy), 32'd1);
    chk("acc_clr", 32'(bus.acc_data), 32'd0);
    chk("ovf_clr", 32'(ovf), 32'd0);
    exp_acc = '0; exp_ovf = 1'b0; k = 0; budget = 0;

    while (k < p && budget < 300) begin
      en = 1'b1; vl = 1'b1;
      if (mode == 1) begin
        en = ($urandom % 5) != 0;
        vl = ($urandom % 4) != 0;
      end else if (mode == 2 && pat_q.size() > 0) begin
        pt = pat_q.pop_front();
        en = pt[1]; vl = pt[0];
      end
      d = (data_q.size() > 0) ? data_q[0] : rand_psum();
      sys_en = en; bus.psum_valid = vl; bus.psum_data = d;
      #1;
      chk("psum_ready", 32'(bus.psum_ready), 32'(en));
      chk("valid_early", 32'(bus.acc_valid), 32'd0);
      tick();
      cyc++; budget++;
      if (en && vl) begin
        r = ref_add(exp_acc, d);
        exp_acc = r[DW-1:0];
        exp_ovf = exp_ovf | r[DW];
        k++;
        if (data_q.size() > 0) void'(data_q.pop_front());
      end
      chk("acc_run", 32'(bus.acc_data), 32'(exp_acc));
    end
    if (budget >= 300) chk("timeout", 32'd1, 32'd0);

    bus.psum_valid = 1'b0; sys_en = 1'b1;
    #1;
    chk("acc_valid", 32'(bus.acc_valid), 32'd1);
    chk("acc_data", 32'(bus.acc_data), 32'(exp_acc));
    chk("ovf", 32'(ovf), 32'(exp_ovf));
    chk("ready_done", 32'(bus.psum_ready), 32'd0);
    if (mode == 0) chk("latency", 32'(cyc), 32'(p + 1));

    hold = (mode == 0) ? 0 : (mode == 2) ? 5 : int'($urandom_range(0, 4));
    for (int i = 0; i < hold; i++) begin
      if (mode == 1 && ($urandom % 3) == 0) begin
        sys_en = 1'b0; bus.acc_ready = 1'b1;
      end else begin
        sys_en = 1'b1; bus.acc_ready = 1'b0;
      end
      start = (i == 1); num_pass = CNT_W'(5);
      bus.psum_valid = 1'b1; bus.psum_data = rand_psum();
      tick();
      chk("hold_valid", 32'(bus.acc_valid), 32'd1);
      chk("hold_data", 32'(bus.acc_data), 32'(exp_acc));
      chk("hold_busy", 32'(busy), 32'd1);
    end
    start = 1'b0; bus.psum_valid = 1'b0; sys_en = 1'b1; bus.acc_ready = 1'b1;
    tick();
    bus.acc_ready = 1'b0;
    chk("drop_valid", 32'(bus.acc_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_data", 32'(bus.acc_data), 32'(exp_acc));
    chk("idle_ready", 32'(bus.psum_ready), 32'd0);
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    rst_n = 1'b0; sys_en = 1'b0; start = 1'b0; num_pass = '0;
    bus.psum_valid = 1'b0; bus.psum_data = '0; bus.acc_ready = 1'b0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(bus.acc_valid), 32'd0);
    chk("rst_data", 32'(bus.acc_data), 32'd0);
    rst_n = 1'b1;
    tick();

    // reset asserted mid-accumulation discards the partial result
    start = 1'b1; num_pass = CNT_W'(3); sys_en = 1'b1;
    tick();
    start = 1'b0; bus.psum_valid = 1'b1; bus.psum_data = DW'(50);
    tick();
    bus.psum_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_data", 32'(bus.acc_data), 32'd0);
    chk("mid_rst_valid", 32'(bus.acc_valid), 32'd0);
    chk("mid_rst_ready", 32'(bus.psum_ready), 32'd0);
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", 32'(busy), 32'd0);

    // basic accumulation 100 - 40 + 7
    data_q = '{DW'(100), DW'(-40), DW'(7)};
    run_job(3, 0);
    chk("basic_67", 32'(exp_acc), 32'd67);

    // bubbles and a frozen cycle between 5 and 9, then 5-cycle backpressure
    data_q = '{DW'(5), DW'(9)};
    pat_q  = '{2'b11, 2'b10, 2'b10, 2'b01, 2'b11};
    run_job(2, 2);

    // start while sys_en low, and num_pass = 0, are both ignored
    sys_en = 1'b0; start = 1'b1; num_pass = CNT_W'(3);
    tick();
    chk("en_low_start", 32'(busy), 32'd0);
    sys_en = 1'b1; num_pass = '0;
    tick();
    start = 1'b0;
    #1;
    chk("zero_busy", 32'(busy), 32'd0);
    chk("zero_ready", 32'(bus.psum_ready), 32'd0);
    chk("zero_data", 32'(bus.acc_data), 32'(exp_acc));

    // 0x7FFFFF twice fits in 25 bits; max positive twice and min negative + -1 overflow
    data_q = '{DW'(32'h7FFFFF), DW'(32'h7FFFFF)};
    run_job(2, 0);
    data_q = '{DW'(MAXV), DW'(MAXV), DW'(1)};
    run_job(3, 0);
    data_q = '{DW'(MINV), DW'(-1)};
    run_job(2, 0);

    // result -1 started right after an overflowing result
    data_q = '{DW'(-1)};
    run_job(1, 0);
    run_job(15, 0);

    for (int j = 0; j < 40; j++) run_job(int'($urandom_range(1, 15)), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
